// File: rtl/melody_player.sv
// Plays a fixed 32-entry song from an internal ROM as a one-hot key select for a tone generator.
// Each entry holds a note code and a duration in beats; every note ends with a short silent gap.
module melody_player #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 1250000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       LOOP,
  output logic [7:0] KEY_OUT,
  output logic       BUSY,
  output logic [4:0] NOTE_IDX,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  localparam logic [23:0] TICK_LAST = 24'(BEAT_CYCLES - 1);
  localparam logic [23:0] GAP_START = 24'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [3:0]  NOTE_END  = 4'd15;

  state_t      state_reg, state_next;
  logic [4:0]  addr_reg, addr_next;
  logic [23:0] tick_reg, tick_next;
  logic [1:0]  beat_reg, beat_next;
  logic [3:0]  note_reg, note_next;
  logic [1:0]  dur_reg, dur_next;
  logic [7:0]  key_reg, key_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        song_end;

  // Song ROM: ascending scale, a two-beat rest, then end markers.
  logic [5:0] rom [32];
  logic [3:0] rom_note;
  logic [1:0] rom_dur;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rom
      localparam logic [3:0] NOTE = (gi < 8) ? 4'(gi + 1) : ((gi == 8) ? 4'd0 : NOTE_END);
      localparam logic [1:0] DUR  = (gi == 8) ? 2'd1 : 2'd0;
      assign rom[gi] = {NOTE, DUR};
    end
  endgenerate

  assign rom_note = rom[addr_reg][5:2];
  assign rom_dur  = rom[addr_reg][1:0];

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    tick_next  = tick_reg;
    beat_next  = beat_reg;
    note_next  = note_reg;
    dur_next   = dur_reg;
    done_next  = 1'b0;
    song_end   = 1'b0;
    key_next   = 8'h00;
    busy_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        addr_next = 5'd0;
        if (START && !STOP) state_next = FETCH;
      end
      FETCH: begin
        if (rom_note == NOTE_END) begin
          song_end = 1'b1;
        end else begin
          state_next = PLAY;
          tick_next  = 24'd0;
          beat_next  = 2'd0;
          note_next  = rom_note;
          dur_next   = rom_dur;
        end
      end
      PLAY: begin
        if (tick_reg == TICK_LAST) begin
          tick_next = 24'd0;
          if (beat_reg == dur_reg) begin
            // Running off the last ROM address counts as reaching the end marker.
            if (addr_reg == 5'd31) begin
              song_end = 1'b1;
            end else begin
              addr_next  = addr_reg + 5'd1;
              state_next = FETCH;
            end
          end else begin
            beat_next = beat_reg + 2'd1;
          end
        end else begin
          tick_next = tick_reg + 24'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (song_end) begin
      addr_next = 5'd0;
      if (LOOP) begin
        state_next = FETCH;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end

    if (STOP && state_reg != IDLE) begin
      state_next = IDLE;
      addr_next  = 5'd0;
      tick_next  = 24'd0;
      beat_next  = 2'd0;
      done_next  = 1'b0;
    end

    // Outputs are computed from the next state so the registered copies line up with it.
    if (state_next == PLAY && !(beat_next == dur_next && tick_next >= GAP_START)
        && note_next >= 4'd1 && note_next <= 4'd8) begin
      key_next = 8'd1 << (note_next - 4'd1);
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_reg <= IDLE;
      addr_reg  <= 5'd0;
      tick_reg  <= 24'd0;
      beat_reg  <= 2'd0;
      note_reg  <= 4'd0;
      dur_reg   <= 2'd0;
      key_reg   <= 8'h00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      tick_reg  <= tick_next;
      beat_reg  <= beat_next;
      note_reg  <= note_next;
      dur_reg   <= dur_next;
      key_reg   <= key_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign KEY_OUT  = key_reg;
  assign BUSY     = busy_reg;
  assign NOTE_IDX = addr_reg;
  assign DONE     = done_reg;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player at BEAT_CYCLES=10, GAP_CYCLES=2: expected per-cycle outputs
// are queued when stimulus is applied and compared one entry per clock.
`timescale 1ns/1ps
module tb_melody_player;

  logic       CLK_50M = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       LOOP = 1'b0;
  logic [7:0] KEY_OUT;
  logic       BUSY;
  logic [4:0] NOTE_IDX;
  logic       DONE;

  melody_player #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut (
    .CLK_50M  (CLK_50M),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .LOOP     (LOOP),
    .KEY_OUT  (KEY_OUT),
    .BUSY     (BUSY),
    .NOTE_IDX (NOTE_IDX),
    .DONE     (DONE)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct packed {
    logic [7:0] key;
    logic       busy;
    logic       done;
    logic [4:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t song_trace [110];
  int   vectors_applied = 0;
  int   miscompares = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned want);
    vectors_applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] key, input logic busy, input logic done,
                              input logic [4:0] idx);
    exp_t e;
    e.key  = key;
    e.busy = busy;
    e.done = done;
    e.idx  = idx;
    return e;
  endfunction

  task automatic tick_and_check();
    exp_t e;
    @(posedge CLK_50M);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("key",  32'(KEY_OUT),  32'(e.key));
      check_val("busy", 32'(BUSY),     32'(e.busy));
      check_val("done", 32'(DONE),     32'(e.done));
      check_val("idx",  32'(NOTE_IDX), 32'(e.idx));
    end
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) tick_and_check();
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(song_trace[i]);
  endtask

  task automatic push_idle(input logic done);
    exp_q.push_back(mk(8'h00, 1'b0, done, 5'd0));
  endtask

  // START pulse: the first expected entry is the FETCH of entry 0.
  task automatic start_song();
    push_range(0, 0);
    START = 1'b1;
    tick_and_check();
    START = 1'b0;
  endtask

  initial begin
    int k;
    logic [7:0] k8;
    // Reference trace from the START edge up to the FETCH of the end marker (entry 9).
    k = 0;
    song_trace[k++] = mk(8'h00, 1'b1, 1'b0, 5'd0);
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < 10; c++) begin
        k8 = (c < 8) ? 8'(1 << n) : 8'h00;
        song_trace[k++] = mk(k8, 1'b1, 1'b0, 5'(n));
      end
      song_trace[k++] = mk(8'h00, 1'b1, 1'b0, 5'(n + 1));
    end
    for (int c = 0; c < 20; c++) song_trace[k++] = mk(8'h00, 1'b1, 1'b0, 5'd8);
    song_trace[k++] = mk(8'h00, 1'b1, 1'b0, 5'd9);

    // Reset, with START held to show reset overrides it.
    START = 1'b1;
    push_idle(1'b0);
    push_idle(1'b0);
    run_all();
    START = 1'b0;
    RST = 1'b0;
    push_idle(1'b0);
    run_all();
    $display("reset: outputs idle");

    // Full song; LOOP set early then cleared before the end, so the song must end with DONE.
    LOOP = 1'b1;
    start_song();
    push_range(1, 49);
    run_all();
    LOOP = 1'b0;
    push_range(50, 109);
    push_idle(1'b1);
    push_idle(1'b0);
    push_idle(1'b0);
    run_all();
    $display("song: played to end with single DONE pulse");

    // Loop enabled mid-song: wraps to entry 0 without DONE, then STOP.
    start_song();
    push_range(1, 49);
    run_all();
    LOOP = 1'b1;
    push_range(50, 109);
    push_range(0, 11);
    run_all();
    STOP = 1'b1;
    push_idle(1'b0);
    tick_and_check();
    STOP = 1'b0;
    LOOP = 1'b0;
    push_idle(1'b0);
    run_all();
    $display("loop: wrapped to entry 0 and stopped");

    // START while busy is ignored; STOP during note 3 aborts.
    start_song();
    push_range(1, 14);
    run_all();
    START = 1'b1;
    push_range(15, 15);
    tick_and_check();
    START = 1'b0;
    push_range(16, 26);
    run_all();
    STOP = 1'b1;
    push_idle(1'b0);
    tick_and_check();
    STOP = 1'b0;
    push_idle(1'b0);
    run_all();
    $display("abort: STOP during note 3");

    // START and STOP together: idle stays idle, playing goes idle.
    START = 1'b1;
    STOP = 1'b1;
    push_idle(1'b0);
    tick_and_check();
    START = 1'b0;
    STOP = 1'b0;
    start_song();
    push_range(1, 5);
    run_all();
    START = 1'b1;
    STOP = 1'b1;
    push_idle(1'b0);
    tick_and_check();
    START = 1'b0;
    STOP = 1'b0;
    push_idle(1'b0);
    run_all();
    $display("start+stop: STOP wins");

    // Reset mid-note silences output with no DONE; a fresh START then plays normally.
    start_song();
    push_range(1, 30);
    run_all();
    RST = 1'b1;
    push_idle(1'b0);
    tick_and_check();
    RST = 1'b0;
    push_idle(1'b0);
    push_idle(1'b0);
    run_all();
    start_song();
    push_range(1, 12);
    run_all();
    $display("reset mid-note: outputs cleared, restart ok");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
